vga_frame_driver: RTL and testbench

//   VGA timing generator and final pixel output stage of the display pipeline.

---
 rtl/vga_frame_driver.sv | 100 ++++++++++
 tb/tb_vga_frame_driver.sv | 138 +++++++++++++
 2 files changed

// File: rtl/vga_frame_driver.sv
// VGA timing generator and DAC output stage: free-running h/v counters, sync/active
// flags delayed to meet the returned RGB332 colour, then one aligned output register.
module vga_frame_driver #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter int PIPE_DLY = 2,
  parameter bit SYNC_POL = 1'b0
) (
  input  logic        clk,
  input  logic        reset,
  output logic [10:0] pixelX,
  output logic [10:0] pixelY,
  input  logic [7:0]  RGBIn,
  output logic        frameTick,
  output logic [7:0]  red,
  output logic [7:0]  green,
  output logic [7:0]  blue,
  output logic        hsync,
  output logic        vsync,
  output logic        blankN
);
  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [10:0] HA      = 11'(H_ACTIVE);
  localparam logic [10:0] HS_BEG  = 11'(H_ACTIVE + H_FP);
  localparam logic [10:0] HS_END  = 11'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [10:0] HT_LAST = 11'(H_TOTAL - 1);
  localparam logic [10:0] VA      = 11'(V_ACTIVE);
  localparam logic [10:0] VA_LAST = 11'(V_ACTIVE - 1);
  localparam logic [10:0] VS_BEG  = 11'(V_ACTIVE + V_FP);
  localparam logic [10:0] VS_END  = 11'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [10:0] VT_LAST = 11'(V_TOTAL - 1);

  logic [10:0] h, v;
  logic [2:0]  tim_cur, tim_tap;   // {active, hsync_on, vsync_on}

  always_ff @(posedge clk) begin
    if (reset) begin
      h         <= '0;
      v         <= '0;
      frameTick <= 1'b0;
    end else begin
      // pulse lands in the same cycle the counters read (0, V_ACTIVE)
      frameTick <= (h == HT_LAST) && (v == VA_LAST);
      if (h == HT_LAST) begin
        h <= '0;
        v <= (v == VT_LAST) ? 11'd0 : v + 11'd1;
      end else begin
        h <= h + 11'd1;
      end
    end
  end

  assign pixelX = h;
  assign pixelY = v;

  assign tim_cur = {(h < HA) && (v < VA),
                    (h >= HS_BEG) && (h < HS_END),
                    (v >= VS_BEG) && (v < VS_END)};

  if (PIPE_DLY == 0) begin : g_nodly
    assign tim_tap = tim_cur;
  end else begin : g_dly
    logic [PIPE_DLY-1:0][2:0] tim_pipe;
    always_ff @(posedge clk) begin
      if (reset) begin
        tim_pipe <= '0;
      end else begin
        tim_pipe[0] <= tim_cur;
        for (int i = 1; i < PIPE_DLY; i++) tim_pipe[i] <= tim_pipe[i-1];
      end
    end
    assign tim_tap = tim_pipe[PIPE_DLY-1];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      red    <= '0;
      green  <= '0;
      blue   <= '0;
      blankN <= 1'b0;
      hsync  <= ~SYNC_POL;
      vsync  <= ~SYNC_POL;
    end else begin
      blankN <= tim_tap[2];
      red    <= tim_tap[2] ? {RGBIn[7:5], RGBIn[7:5], RGBIn[7:6]} : 8'd0;
      green  <= tim_tap[2] ? {RGBIn[4:2], RGBIn[4:2], RGBIn[4:3]} : 8'd0;
      blue   <= tim_tap[2] ? {4{RGBIn[1:0]}} : 8'd0;
      hsync  <= tim_tap[1] ? SYNC_POL : ~SYNC_POL;
      vsync  <= tim_tap[0] ? SYNC_POL : ~SYNC_POL;
    end
  end
endmodule

// File: tb/tb_vga_frame_driver.sv
// Bench for vga_frame_driver: full-size and reduced-timing instances driven with random
// colour and resets, each compared every cycle against an arithmetic timing model.
module tb_vga_frame_driver;
  typedef struct {
    int ha, hf, hs, hb, va, vf, vs, vb, d;
  } cfg_t;

  localparam cfg_t BIG = '{640, 16, 96, 48, 480, 10, 2, 33, 2};
  localparam cfg_t SM2 = '{16, 2, 4, 3, 10, 2, 2, 3, 2};
  localparam cfg_t SM0 = '{16, 2, 4, 3, 10, 2, 2, 3, 0};
  localparam int NCYC = 20000;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic [7:0] RGBIn = 8'd0;

  logic [10:0] b_px, b_py, s2_px, s2_py, s0_px, s0_py;
  logic        b_ft, b_hs, b_vs, b_bn, s2_ft, s2_hs, s2_vs, s2_bn, s0_ft, s0_hs, s0_vs, s0_bn;
  logic [7:0]  b_r, b_g, b_b, s2_r, s2_g, s2_b, s0_r, s0_g, s0_b;

  always #5 clk = ~clk;

  vga_frame_driver u_big (
    .clk(clk), .reset(reset), .pixelX(b_px), .pixelY(b_py), .RGBIn(RGBIn),
    .frameTick(b_ft), .red(b_r), .green(b_g), .blue(b_b),
    .hsync(b_hs), .vsync(b_vs), .blankN(b_bn));

  vga_frame_driver #(.H_ACTIVE(16), .H_FP(2), .H_SYNC(4), .H_BP(3),
                     .V_ACTIVE(10), .V_FP(2), .V_SYNC(2), .V_BP(3), .PIPE_DLY(2)) u_sm2 (
    .clk(clk), .reset(reset), .pixelX(s2_px), .pixelY(s2_py), .RGBIn(RGBIn),
    .frameTick(s2_ft), .red(s2_r), .green(s2_g), .blue(s2_b),
    .hsync(s2_hs), .vsync(s2_vs), .blankN(s2_bn));

  vga_frame_driver #(.H_ACTIVE(16), .H_FP(2), .H_SYNC(4), .H_BP(3),
                     .V_ACTIVE(10), .V_FP(2), .V_SYNC(2), .V_BP(3), .PIPE_DLY(0)) u_sm0 (
    .clk(clk), .reset(reset), .pixelX(s0_px), .pixelY(s0_py), .RGBIn(RGBIn),
    .frameTick(s0_ft), .red(s0_r), .green(s0_g), .blue(s0_b),
    .hsync(s0_hs), .vsync(s0_vs), .blankN(s0_bn));

  int errs = 0;
  int checks = 0;
  int pos = 0;           // clock edges since the most recent reset edge
  logic [7:0] rgb_edge;  // colour sampled at the latest edge

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errs++;
      $display("FAIL %s at pos %0d: got %0h want %0h", tag, pos, obs, exp);
    end
  endtask

  task automatic check_dut(input string nm, input cfg_t c,
                           input logic [10:0] px, input logic [10:0] py, input logic ft,
                           input logic [7:0] r, input logic [7:0] g, input logic [7:0] b,
                           input logic hs, input logic vs, input logic bn);
    int ht, vt, eh, ev, q, hq, vq;
    bit act, hsa, vsa;
    logic [2:0] cr, cg;
    logic [1:0] cb;
    ht = c.ha + c.hf + c.hs + c.hb;
    vt = c.va + c.vf + c.vs + c.vb;
    eh = pos % ht;
    ev = (pos / ht) % vt;
    act = 0; hsa = 0; vsa = 0;
    if (pos >= c.d + 1) begin
      q   = pos - c.d - 1;
      hq  = q % ht;
      vq  = (q / ht) % vt;
      act = (hq < c.ha) && (vq < c.va);
      hsa = (hq >= c.ha + c.hf) && (hq < c.ha + c.hf + c.hs);
      vsa = (vq >= c.va + c.vf) && (vq < c.va + c.vf + c.vs);
    end
    cr = rgb_edge[7:5];
    cg = rgb_edge[4:2];
    cb = rgb_edge[1:0];
    chk({nm, ".pixelX"}, 32'(px), eh);
    chk({nm, ".pixelY"}, 32'(py), ev);
    chk({nm, ".frameTick"}, 32'(ft), 32'(eh == 0 && ev == c.va));
    chk({nm, ".red"},   32'(r), act ? 32'({cr, cr, cr[2:1]}) : 0);
    chk({nm, ".green"}, 32'(g), act ? 32'({cg, cg, cg[2:1]}) : 0);
    chk({nm, ".blue"},  32'(b), act ? 32'({cb, cb, cb, cb}) : 0);
    chk({nm, ".hsync"}, 32'(hs), 32'(!hsa));
    chk({nm, ".vsync"}, 32'(vs), 32'(!vsa));
    chk({nm, ".blankN"}, 32'(bn), 32'(act));
  endtask

  initial begin
    bit started = 0;
    bit mid_done = 0;
    bit prev_hs = 1;
    int first_fall = -1;
    int rst_hold = 0;
    for (int cyc = 0; cyc < NCYC; cyc++) begin
      @(posedge clk);
      if (reset) begin
        pos = 0;
        started = 1;
      end else begin
        pos++;
      end
      rgb_edge = RGBIn;
      @(negedge clk);
      if (started) begin
        check_dut("big", BIG, b_px, b_py, b_ft, b_r, b_g, b_b, b_hs, b_vs, b_bn);
        check_dut("sm2", SM2, s2_px, s2_py, s2_ft, s2_r, s2_g, s2_b, s2_hs, s2_vs, s2_bn);
        check_dut("sm0", SM0, s0_px, s0_py, s0_ft, s0_r, s0_g, s0_b, s0_hs, s0_vs, s0_bn);
        if (!mid_done && first_fall < 0 && prev_hs && !b_hs) first_fall = pos;
        prev_hs = b_hs;
      end
      if (cyc == 1500) chk("big.first_hsync_fall", first_fall, 659);

      // reset: initial 3 cycles, one mid-line pulse at (300,10), random pulses later
      if (cyc < 2) begin
        reset = 1'b1;
      end else if (!mid_done && cyc > 3 && pos == 10 * 800 + 300) begin
        reset = 1'b1;
        mid_done = 1;
      end else if (rst_hold > 0) begin
        reset = 1'b1;
        rst_hold--;
      end else if (cyc > 9000 && $urandom_range(0, 1499) == 0) begin
        reset = 1'b1;
        rst_hold = $urandom_range(0, 1);
      end else begin
        reset = 1'b0;
      end

      case ($urandom_range(0, 3))
        0: RGBIn = 8'b101_010_01;
        1: RGBIn = 8'hFF;
        default: RGBIn = 8'($urandom);
      endcase
    end
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
